// File: rtl/find_ones_stream_pkg.sv
// Shared width helper for the find_ones_stream block and its selector.
package find_ones_stream_pkg;

    // Bits needed to index n items, never less than one.
    function automatic int log2up(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/find_ones_stream_if.sv
// Vector-in / position-beat-out handshake bundle; master is the environment, slave is the block.
interface find_ones_stream_if import find_ones_stream_pkg::*; #(
    parameter int N     = 256,
    parameter int LANES = 4,
    parameter int LOGN  = log2up(N),
    parameter int BEATW = log2up(N / LANES + 1)
);
    logic                         in_valid;
    logic [N-1:0]                 in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic [LANES-1:0][LOGN-1:0]   out_pos;
    logic [LANES-1:0]             out_mask;
    logic                         out_last;
    logic [LOGN:0]                out_count;
    logic [BEATW-1:0]             out_beat;
    logic                         out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_pos, out_mask, out_last, out_count, out_beat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_pos, out_mask, out_last, out_count, out_beat
    );
endinterface

// File: rtl/find_ones_stream_find_first_k.sv
// Picks the first K set bits of vec (lowest first, or highest when MSB_FIRST).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to apply the clear mask.
module find_first_k import find_ones_stream_pkg::*; #(
    parameter int N         = 256,
    parameter int K         = 4,
    parameter int MSB_FIRST = 0,
    parameter int LOGN      = log2up(N)
) (
    input  logic [N-1:0]           vec,
    output logic [K-1:0][LOGN-1:0] pos,
    output logic [K-1:0]           vld,
    output logic [N-1:0]           clr
);

    logic [N-1:0]    rem;
    logic [LOGN-1:0] idx;
    logic [LOGN-1:0] pick;
    logic            found;

    // K cascaded priority encoders, each blind to the bits already picked.
    always_comb begin
        rem   = vec;
        idx   = '0;
        pick  = '0;
        found = 1'b0;
        pos   = '0;
        vld   = '0;
        clr   = '0;
        for (int k = 0; k < K; k++) begin
            found = 1'b0;
            pick  = '0;
            for (int i = 0; i < N; i++) begin
                idx = (MSB_FIRST != 0) ? LOGN'(N - 1 - i) : LOGN'(i);
                if (!found && rem[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
            if (found) begin
                pos[k]    = pick;
                vld[k]    = 1'b1;
                clr[pick] = 1'b1;
                rem[pick] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/find_ones_stream.sv
// Streams the set-bit positions of each accepted vector, up to LANES per beat.
// Latency: first beat one cycle after accept; back-to-back vectors with no bubble.
// Backpressure: beats hold while out_ready is low; in_ready follows the last-beat fire.
module find_ones_stream import find_ones_stream_pkg::*; #(
    parameter int N         = 256,
    parameter int LANES     = 4,
    parameter int MSB_FIRST = 0,
    parameter int LOGN      = log2up(N),
    parameter int BEATW     = log2up(N / LANES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    find_ones_stream_if.slave   bus
);

    localparam int CW = LOGN + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                     state;
    logic [N-1:0]               res;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              rem_q;
    logic [BEATW-1:0]           beat_q;

    logic [LANES-1:0][LOGN-1:0] sel_pos;
    logic [LANES-1:0]           sel_vld;
    logic [N-1:0]               sel_clr;
    logic [CW-1:0]              in_pop;
    logic [CW-1:0]              lane_pop;
    logic                       last;
    logic                       in_fire;
    logic                       out_fire;

    find_first_k #(
        .N         (N),
        .K         (LANES),
        .MSB_FIRST (MSB_FIRST),
        .LOGN      (LOGN)
    ) u_sel (
        .vec (res),
        .pos (sel_pos),
        .vld (sel_vld),
        .clr (sel_clr)
    );

    always_comb begin
        in_pop = '0;
        for (int i = 0; i < N; i++) begin
            in_pop = in_pop + CW'(bus.in_data[i]);
        end
    end

    always_comb begin
        lane_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_pop = lane_pop + CW'(sel_vld[k]);
        end
    end

    // The remaining-count register replaces a full-width popcount of res every beat.
    assign last         = (state == DRAIN) && (rem_q <= CW'(LANES));
    assign out_fire     = (state == DRAIN) && bus.out_ready;
    assign bus.in_ready = (state == IDLE) || (out_fire && last);
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (state == DRAIN);
    assign bus.out_pos   = sel_pos;
    assign bus.out_mask  = sel_vld;
    assign bus.out_last  = last;
    assign bus.out_count = count_q;
    assign bus.out_beat  = beat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            res     <= '0;
            count_q <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
        end else if (in_fire) begin
            state   <= DRAIN;
            res     <= bus.in_data;
            count_q <= in_pop;
            rem_q   <= in_pop;
            beat_q  <= '0;
        end else if (out_fire) begin
            // On the last beat this empties res, so IDLE always sees res == 0.
            res   <= res & ~sel_clr;
            rem_q <= rem_q - lane_pop;
            if (last) begin
                state <= IDLE;
            end else begin
                beat_q <= beat_q + BEATW'(1);
            end
        end
    end

endmodule

// File: tb/tb_find_ones_stream.sv
// Random and directed vectors into ascending and descending instances, scored against a list model.
module tb_find_ones_stream;
    import find_ones_stream_pkg::*;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int LOGN  = log2up(N);
    localparam int BEATW = log2up(N / LANES + 1);
    localparam int CW    = LOGN + 1;

    typedef struct packed {
        logic [LANES-1:0][LOGN-1:0] pos;
        logic [LANES-1:0]           mask;
        logic                       last;
        logic [CW-1:0]              count;
        logic [BEATW-1:0]           beat;
    } beat_t;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic [N-1:0] in_data   = '0;
    logic         out_ready = 1'b0;

    int tests     = 0;
    int fails     = 0;
    int rdy_mode  = 0;
    int rdy_phase = 0;

    beat_t qa[$];
    beat_t qd[$];

    find_ones_stream_if #(.N(N), .LANES(LANES)) bus_a ();
    find_ones_stream_if #(.N(N), .LANES(LANES)) bus_d ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_d.in_valid  = in_valid;
    assign bus_d.in_data   = in_data;
    assign bus_d.out_ready = out_ready;

    find_ones_stream #(.N(N), .LANES(LANES), .MSB_FIRST(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    find_ones_stream #(.N(N), .LANES(LANES), .MSB_FIRST(1)) dut_d (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t pack(input logic [LANES-1:0][LOGN-1:0] p, input logic [LANES-1:0] m,
                                   input logic l, input logic [CW-1:0] c, input logic [BEATW-1:0] b);
        beat_t r;
        r.pos   = p;
        r.mask  = m;
        r.last  = l;
        r.count = c;
        r.beat  = b;
        return r;
    endfunction

    task automatic cmp_beat(input string tag, input beat_t got, input beat_t exp);
        chk({tag, ".pos"},   64'(got.pos),   64'(exp.pos));
        chk({tag, ".mask"},  64'(got.mask),  64'(exp.mask));
        chk({tag, ".last"},  64'(got.last),  64'(exp.last));
        chk({tag, ".count"}, 64'(got.count), 64'(exp.count));
        chk({tag, ".beat"},  64'(got.beat),  64'(exp.beat));
    endtask

    // Reference: list the set positions in the chosen order and cut the list into LANES-sized beats.
    task automatic push_exp(input logic [N-1:0] v);
        int    lst[$];
        int    nb;
        int    bit_i;
        beat_t e;
        for (int o = 0; o < 2; o++) begin
            lst.delete();
            for (int i = 0; i < N; i++) begin
                bit_i = (o == 0) ? i : N - 1 - i;
                if (v[bit_i]) lst.push_back(bit_i);
            end
            nb = (lst.size() == 0) ? 1 : (lst.size() + LANES - 1) / LANES;
            for (int b = 0; b < nb; b++) begin
                e       = '0;
                e.last  = (b == nb - 1);
                e.count = CW'(lst.size());
                e.beat  = BEATW'(b);
                for (int k = 0; k < LANES; k++) begin
                    if (b * LANES + k < lst.size()) begin
                        e.pos[k]  = LOGN'(lst[b * LANES + k]);
                        e.mask[k] = 1'b1;
                    end
                end
                if (o == 0) qa.push_back(e);
                else        qd.push_back(e);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = (rdy_phase % 3 == 0);
                rdy_phase++;
            end
            default: out_ready = 1'b0;
        endcase
    end

    logic  pend    = 1'b0;
    logic  stall_a = 1'b0;
    logic  stall_d = 1'b0;
    beat_t held_a;
    beat_t held_d;

    always @(negedge clk) begin
        beat_t ga;
        beat_t gd;
        beat_t e;
        if (reset) begin
            pend    = 1'b0;
            stall_a = 1'b0;
            stall_d = 1'b0;
        end else begin
            ga = pack(bus_a.out_pos, bus_a.out_mask, bus_a.out_last, bus_a.out_count, bus_a.out_beat);
            gd = pack(bus_d.out_pos, bus_d.out_mask, bus_d.out_last, bus_d.out_count, bus_d.out_beat);
            if (pend) chk("first_beat_latency", 64'(bus_a.out_valid), 64'd1);
            pend = in_valid && bus_a.in_ready;
            if (in_valid && bus_a.in_ready && bus_a.out_valid)
                chk("accept_only_on_last_fire", 64'(bus_a.out_last && out_ready), 64'd1);
            if (stall_a) chk("hold_asc", 64'(ga), 64'(held_a));
            if (stall_d) chk("hold_dsc", 64'(gd), 64'(held_d));
            if (bus_a.out_valid && out_ready) begin
                if (bus_a.out_last) chk("in_ready_on_last", 64'(bus_a.in_ready), 64'd1);
                if (qa.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL asc_extra_beat: got beat %0h, expected no beat", ga);
                end else begin
                    e = qa.pop_front();
                    cmp_beat("asc", ga, e);
                end
            end
            if (bus_d.out_valid && out_ready) begin
                if (qd.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dsc_extra_beat: got beat %0h, expected no beat", gd);
                end else begin
                    e = qd.pop_front();
                    cmp_beat("dsc", gd, e);
                end
            end
            stall_a = bus_a.out_valid && !out_ready;
            stall_d = bus_d.out_valid && !out_ready;
            held_a  = ga;
            held_d  = gd;
        end
    end

    // Entered and left at posedge+1; holds in_valid until accepted.
    task automatic send(input logic [N-1:0] v);
        int budget;
        logic done;
        in_valid = 1'b1;
        in_data  = v;
        budget   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                push_exp(v);
                done = 1'b1;
            end else if (budget > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
                done = 1'b1;
            end
            budget++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = N'($urandom);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((qa.size() != 0 || qd.size() != 0) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (qa.size() != 0 || qd.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", qa.size() + qd.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] v;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("rst_out_mask",  64'(bus_a.out_mask),  64'd0);
        chk("rst_out_pos",   64'(bus_a.out_pos),   64'd0);
        chk("rst_out_last",  64'(bus_a.out_last),  64'd0);
        chk("rst_out_count", 64'(bus_a.out_count), 64'd0);
        chk("rst_out_beat",  64'(bus_a.out_beat),  64'd0);
        chk("rst_dsc_valid", 64'(bus_d.out_valid), 64'd0);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        send(16'h8421);
        send(16'hFFFF);
        send(16'h0013);
        send(16'h0000);
        wait_drain();

        rdy_phase = 0;
        rdy_mode  = 2;
        send(16'hFFFF);
        send(16'h0001);
        wait_drain();

        // Reset lands while beat 1 of an all-ones vector is presented.
        rdy_mode = 0;
        send(16'hFFFF);
        @(posedge clk);
        #1;
        rdy_mode  = 3;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        qa.delete();
        qd.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("midrst_out_count", 64'(bus_a.out_count), 64'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send(16'h0100);
        wait_drain();

        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       v = '0;
                1:       v = '1;
                2:       v = N'($urandom);
                3:       v = N'($urandom & $urandom);
                4:       v = N'(1) << $urandom_range(0, N - 1);
                default: v = N'($urandom | $urandom);
            endcase
            send(v);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "global timeout");
    end

endmodule
